// File: rtl/axi_cfg_pkg.sv
// Shared addresses, control codes, state enums and AXI response codes
// for the AXI-Lite configuration sequencer (AXI_CFG_READBACK_EN adds RD_CHK).
package axi_cfg_pkg;

   localparam logic [31:0] ADDR_CTRL   = 32'h0000_0000;
   localparam logic [31:0] ADDR_STATUS = 32'h0000_0004;
   localparam logic [31:0] ADDR_ENABLE = 32'h0000_0040;
   localparam logic [31:0] ADDR_WEIGHT = 32'h0000_0044;

   localparam logic [31:0] CTRL_START = 32'd1;
   localparam logic [31:0] CTRL_DONE  = 32'd2;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WR_EN,
      S_WR_WGT,
      S_RD_CHK,
      S_WR_GO,
      S_POLL,
      S_GAP,
      S_WR_ACK,
      S_DONE
   } seq_state_e;

   typedef enum logic [2:0] {
      T_IDLE,
      T_WR,
      T_WRESP,
      T_RD,
      T_RRESP
   } txn_state_e;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_e;

endpackage

// File: rtl/axi_cfg_sequencer_txn.sv
// Single-transaction AXI-Lite master engine; owns every AXI output.
// A new command may be accepted in the same cycle the previous one completes.
module axi_lite_txn
   import axi_cfg_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        cmd_done,
   output logic [31:0] cmd_rdata,
   output logic        cmd_err,
   output logic [31:0] ARADDR,
   output logic        ARVALID,
   input  logic        ARREADY,
   input  logic [31:0] RDATA,
   input  logic [1:0]  RRESP,
   input  logic        RVALID,
   output logic        RREADY,
   output logic [31:0] AWADDR,
   output logic        AWVALID,
   input  logic        AWREADY,
   output logic [31:0] WDATA,
   output logic [3:0]  WSTRB,
   output logic        WVALID,
   input  logic        WREADY,
   input  logic [1:0]  BRESP,
   input  logic        BVALID,
   output logic        BREADY
);

   txn_state_e tstate, tstate_n;
   logic wr_fin, rd_fin, accept, aw_ok, w_ok;

   assign wr_fin    = (tstate == T_WRESP) && BVALID && BREADY;
   assign rd_fin    = (tstate == T_RRESP) && RVALID && RREADY;
   assign cmd_done  = wr_fin | rd_fin;
   assign cmd_rdata = RDATA;
   assign cmd_err   = wr_fin ? (BRESP != RESP_OKAY)
                             : (rd_fin && (RRESP != RESP_OKAY));
   assign accept    = cmd_valid && ((tstate == T_IDLE) || cmd_done);
   // a channel is finished once its VALID is gone or handshakes now
   assign aw_ok     = !AWVALID || AWREADY;
   assign w_ok      = !WVALID || WREADY;

   always_comb begin
      tstate_n = tstate;
      unique case (tstate)
         T_IDLE:  tstate_n = T_IDLE;
         T_WR:    if (aw_ok && w_ok) tstate_n = T_WRESP;
         T_WRESP: if (wr_fin) tstate_n = T_IDLE;
         T_RD:    if (ARREADY) tstate_n = T_RRESP;
         T_RRESP: if (rd_fin) tstate_n = T_IDLE;
         default: tstate_n = T_IDLE;
      endcase
      if (accept) tstate_n = cmd_write ? T_WR : T_RD;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) tstate <= T_IDLE;
      else       tstate <= tstate_n;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ARADDR  <= '0;
         ARVALID <= 1'b0;
         RREADY  <= 1'b0;
         AWADDR  <= '0;
         AWVALID <= 1'b0;
         WDATA   <= '0;
         WSTRB   <= '0;
         WVALID  <= 1'b0;
         BREADY  <= 1'b0;
      end else begin
         if (AWVALID && AWREADY) AWVALID <= 1'b0;
         if (WVALID && WREADY)   WVALID  <= 1'b0;
         if ((tstate == T_WR) && aw_ok && w_ok) BREADY <= 1'b1;
         if (wr_fin) BREADY <= 1'b0;
         if (ARVALID && ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
         end
         if (rd_fin) RREADY <= 1'b0;
         if (accept) begin
            if (cmd_write) begin
               AWADDR  <= cmd_addr;
               AWVALID <= 1'b1;
               WDATA   <= cmd_wdata;
               WSTRB   <= 4'hF;
               WVALID  <= 1'b1;
            end else begin
               ARADDR  <= cmd_addr;
               ARVALID <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/axi_cfg_sequencer.sv
// Host-less AXI-Lite configurator: enable, weights, kick, poll, ack.
// Define AXI_CFG_READBACK_EN to verify enable/weights by readback before kicking.
module axi_cfg_sequencer
   import axi_cfg_pkg::*;
#(
   parameter int NUM_WEIGHTS = 10,
   parameter int POLL_GAP    = 16,
   parameter int POLL_MAX    = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [32*NUM_WEIGHTS-1:0] weights,
   output logic [31:0]              ARADDR,
   output logic                     ARVALID,
   input  logic                     ARREADY,
   input  logic [31:0]              RDATA,
   input  logic [1:0]               RRESP,
   input  logic                     RVALID,
   output logic                     RREADY,
   output logic [31:0]              AWADDR,
   output logic                     AWVALID,
   input  logic                     AWREADY,
   output logic [31:0]              WDATA,
   output logic [3:0]               WSTRB,
   output logic                     WVALID,
   input  logic                     WREADY,
   input  logic [1:0]               BRESP,
   input  logic                     BVALID,
   output logic                     BREADY,
   output logic                     busy,
   output logic                     done,
   output logic                     error
);

   localparam int IW = (NUM_WEIGHTS > 0) ? $clog2(NUM_WEIGHTS + 1) : 1;
   localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [IW-1:0] LAST_W   = IW'(NUM_WEIGHTS - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

   seq_state_e state, state_n;
   logic [IW-1:0] idx, idx_n, idx_p1;
   logic [GW-1:0] gap_cnt, gap_n;
   logic [31:0]   poll_cnt, poll_n;
   logic          err_q, err_n;
   logic          cmd_valid, cmd_write, cmd_done, cmd_err;
   logic [31:0]   cmd_addr, cmd_wdata, cmd_rdata, wgt_nxt;

   assign idx_p1  = idx + 1'b1;
   assign wgt_nxt = weights[32*int'(idx_p1) +: 32];

`ifdef AXI_CFG_READBACK_EN
   logic [31:0] rb_exp;
   // readback slot 0 is the enable register, slot k is weight k-1
   assign rb_exp = (idx == '0) ? 32'd1
                 : weights[32*(int'(idx) - 1) +: 32];
`endif

   always_comb begin
      state_n   = state;
      idx_n     = idx;
      poll_n    = poll_cnt;
      gap_n     = gap_cnt;
      err_n     = err_q;
      cmd_valid = 1'b0;
      cmd_write = 1'b1;
      cmd_addr  = '0;
      cmd_wdata = '0;
      unique case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_n   = S_WR_EN;
               idx_n     = '0;
               poll_n    = '0;
               gap_n     = '0;
               err_n     = 1'b0;
               cmd_valid = 1'b1;
               cmd_addr  = ADDR_ENABLE;
               cmd_wdata = 32'd1;
            end
         end
         S_WR_EN: begin
            if (cmd_done) begin
               if (cmd_err) begin
                  state_n = S_DONE;
                  err_n   = 1'b1;
               end else begin
                  state_n   = S_WR_WGT;
                  cmd_valid = 1'b1;
                  cmd_addr  = ADDR_WEIGHT;
                  cmd_wdata = weights[31:0];
               end
            end
         end
         S_WR_WGT: begin
            if (cmd_done) begin
               if (cmd_err) begin
                  state_n = S_DONE;
                  err_n   = 1'b1;
               end else if (idx == LAST_W) begin
`ifdef AXI_CFG_READBACK_EN
                  state_n   = S_RD_CHK;
                  idx_n     = '0;
                  cmd_valid = 1'b1;
                  cmd_write = 1'b0;
                  cmd_addr  = ADDR_ENABLE;
`else
                  state_n   = S_WR_GO;
                  cmd_valid = 1'b1;
                  cmd_addr  = ADDR_CTRL;
                  cmd_wdata = CTRL_START;
`endif
               end else begin
                  idx_n     = idx_p1;
                  cmd_valid = 1'b1;
                  cmd_addr  = ADDR_WEIGHT + (32'(idx_p1) << 2);
                  cmd_wdata = wgt_nxt;
               end
            end
         end
`ifdef AXI_CFG_READBACK_EN
         S_RD_CHK: begin
            if (cmd_done) begin
               if (cmd_err || (cmd_rdata != rb_exp)) begin
                  state_n = S_DONE;
                  err_n   = 1'b1;
               end else if (idx == IW'(NUM_WEIGHTS)) begin
                  state_n   = S_WR_GO;
                  cmd_valid = 1'b1;
                  cmd_addr  = ADDR_CTRL;
                  cmd_wdata = CTRL_START;
               end else begin
                  idx_n     = idx_p1;
                  cmd_valid = 1'b1;
                  cmd_write = 1'b0;
                  cmd_addr  = ADDR_ENABLE + (32'(idx_p1) << 2);
               end
            end
         end
`endif
         S_WR_GO: begin
            if (cmd_done) begin
               if (cmd_err) begin
                  state_n = S_DONE;
                  err_n   = 1'b1;
               end else begin
                  state_n   = S_POLL;
                  poll_n    = 32'd1;
                  cmd_valid = 1'b1;
                  cmd_write = 1'b0;
                  cmd_addr  = ADDR_CTRL;
               end
            end
         end
         S_POLL: begin
            if (cmd_done) begin
               if (cmd_err) begin
                  state_n = S_DONE;
                  err_n   = 1'b1;
               end else if (cmd_rdata == CTRL_DONE) begin
                  state_n   = S_WR_ACK;
                  cmd_valid = 1'b1;
                  cmd_addr  = ADDR_CTRL;
                  cmd_wdata = CTRL_DONE;
               end else if ((POLL_MAX != 0) && (poll_cnt == 32'(POLL_MAX))) begin
                  state_n = S_DONE;
                  err_n   = 1'b1;
               end else begin
                  state_n = S_GAP;
                  gap_n   = '0;
               end
            end
         end
         S_GAP: begin
            if (gap_cnt == GAP_LAST) begin
               state_n   = S_POLL;
               poll_n    = poll_cnt + 1'b1;
               cmd_valid = 1'b1;
               cmd_write = 1'b0;
               cmd_addr  = ADDR_CTRL;
            end else begin
               gap_n = gap_cnt + 1'b1;
            end
         end
         S_WR_ACK: begin
            if (cmd_done) begin
               state_n = S_DONE;
               err_n   = cmd_err;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         idx      <= '0;
         poll_cnt <= '0;
         gap_cnt  <= '0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_n;
         idx      <= idx_n;
         poll_cnt <= poll_n;
         gap_cnt  <= gap_n;
         err_q    <= err_n;
      end
   end

   assign busy  = (state != S_IDLE) && (state != S_DONE);
   assign done  = (state == S_DONE);
   assign error = err_q;

   axi_lite_txn u_txn (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .cmd_done  (cmd_done),
      .cmd_rdata (cmd_rdata),
      .cmd_err   (cmd_err),
      .ARADDR    (ARADDR),
      .ARVALID   (ARVALID),
      .ARREADY   (ARREADY),
      .RDATA     (RDATA),
      .RRESP     (RRESP),
      .RVALID    (RVALID),
      .RREADY    (RREADY),
      .AWADDR    (AWADDR),
      .AWVALID   (AWVALID),
      .AWREADY   (AWREADY),
      .WDATA     (WDATA),
      .WSTRB     (WSTRB),
      .WVALID    (WVALID),
      .WREADY    (WREADY),
      .BRESP     (BRESP),
      .BVALID    (BVALID),
      .BREADY    (BREADY)
   );

endmodule

// File: tb/tb_axi_cfg_sequencer.sv
// Directed bench for axi_cfg_sequencer with a behavioural AXI-Lite slave.
// Build with AXI_CFG_READBACK_EN to add the readback-corruption run.
module tb_axi_cfg_sequencer;
   import axi_cfg_pkg::*;

   localparam int NW   = 10;
   localparam int GAP  = 3;
   localparam int PMAX = 4;
   localparam logic [31:0] WV [NW] = '{1, 3, 3, 15, 6, 25, 3, 15, 1, 3};
`ifdef AXI_CFG_READBACK_EN
   localparam int RB_CYC = (NW + 1) * 2;
`else
   localparam int RB_CYC = 0;
`endif
   localparam int RUN_CYC = (NW + 3) * 2 + 2 * (2 + GAP) + 2 + RB_CYC;

   logic clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [32*NW-1:0] weights;
   logic [31:0] ARADDR, RDATA, AWADDR, WDATA;
   logic ARVALID, ARREADY, RVALID, RREADY;
   logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
   logic [1:0] RRESP, BRESP;
   logic [3:0] WSTRB;
   logic busy, done, error;

   axi_cfg_sequencer #(
      .NUM_WEIGHTS (NW),
      .POLL_GAP    (GAP),
      .POLL_MAX    (PMAX)
   ) dut (
      .clk (clk), .reset (reset), .start (start), .weights (weights),
      .ARADDR (ARADDR), .ARVALID (ARVALID), .ARREADY (ARREADY),
      .RDATA (RDATA), .RRESP (RRESP), .RVALID (RVALID), .RREADY (RREADY),
      .AWADDR (AWADDR), .AWVALID (AWVALID), .AWREADY (AWREADY),
      .WDATA (WDATA), .WSTRB (WSTRB), .WVALID (WVALID), .WREADY (WREADY),
      .BRESP (BRESP), .BVALID (BVALID), .BREADY (BREADY),
      .busy (busy), .done (done), .error (error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // slave configuration and logs
   bit stall = 0, corrupt = 0;
   int err_at = 0, ctrl_ok_at = 0;
   int wr_n = 0, n_rd = 0, n_ctrl = 0, viol = 0;
   logic [31:0] wr_addr[$], wr_data[$];
   int ar_cyc[$];
   logic [31:0] mem [16];

   bit p_aw, p_w, p_b, p_ar, p_r, pv_aw, pv_w, pv_ar;
   bit aw_got, w_got, b_arm, ar_got;
   logic [31:0] p_awaddr, p_wdata, p_araddr, c_awaddr, c_wdata, c_araddr;
   logic [31:0] pa_aw, pd_w, pa_ar;
   int bdly, rdly;

   initial begin
      {AWREADY, WREADY, BVALID, ARREADY, RVALID} = '0;
      {BRESP, RRESP} = '0;
      RDATA = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            {AWREADY, WREADY, BVALID, ARREADY, RVALID} = '0;
            {p_aw, p_w, p_b, p_ar, p_r, pv_aw, pv_w, pv_ar} = '0;
            {aw_got, w_got, b_arm, ar_got} = '0;
            continue;
         end
         if (pv_aw && !p_aw && (!AWVALID || AWADDR !== pa_aw)) viol++;
         if (pv_w && !p_w && (!WVALID || WDATA !== pd_w)) viol++;
         if (pv_ar && !p_ar && (!ARVALID || ARADDR !== pa_ar)) viol++;
         if (p_aw) begin aw_got = 1; c_awaddr = p_awaddr; end
         if (p_w) begin w_got = 1; c_wdata = p_wdata; end
         if (p_b) BVALID = 0;
         if (p_r) RVALID = 0;
         if (p_ar) begin
            ar_got = 1;
            c_araddr = p_araddr;
            rdly = stall ? $urandom_range(0, 5) : 0;
            n_rd++;
            if (p_araddr == ADDR_CTRL) begin
               n_ctrl++;
               ar_cyc.push_back(cyc);
            end
         end
         if (aw_got && w_got && !b_arm) begin
            b_arm = 1;
            bdly = stall ? $urandom_range(0, 5) : 0;
         end
         if (b_arm) begin
            if (bdly == 0) begin
               wr_n++;
               wr_addr.push_back(c_awaddr);
               wr_data.push_back(c_wdata);
               if (c_awaddr >= ADDR_ENABLE) mem[(c_awaddr >> 2) & 15] = c_wdata;
               BRESP = (wr_n == err_at) ? 2'b10 : 2'b00;
               BVALID = 1;
               {aw_got, w_got, b_arm} = '0;
            end else bdly--;
         end
         if (ar_got) begin
            if (rdly == 0) begin
               if (c_araddr == ADDR_CTRL)
                  RDATA = (ctrl_ok_at != 0 && n_ctrl == ctrl_ok_at) ? 32'd2 : 32'd0;
               else
                  RDATA = mem[(c_araddr >> 2) & 15] ^ ((corrupt && c_araddr == 32'h58) ? 32'd1 : 32'd0);
               RRESP = 2'b00;
               RVALID = 1;
               ar_got = 0;
            end else rdly--;
         end
         AWREADY = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
         WREADY  = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
         ARREADY = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
         p_aw = AWVALID && AWREADY; p_awaddr = AWADDR;
         p_w  = WVALID && WREADY;   p_wdata  = WDATA;
         p_ar = ARVALID && ARREADY; p_araddr = ARADDR;
         p_b  = BVALID && BREADY;
         p_r  = RVALID && RREADY;
         pv_aw = AWVALID; pa_aw = AWADDR;
         pv_w  = WVALID;  pd_w  = WDATA;
         pv_ar = ARVALID; pa_ar = ARADDR;
      end
   end

   task automatic clr();
      wr_addr.delete(); wr_data.delete(); ar_cyc.delete();
      wr_n = 0; n_rd = 0; n_ctrl = 0; viol = 0;
   endtask

   task automatic run_start(input string tag, output int t0);
      @(negedge clk);
      start = 1;
      t0 = cyc;
      @(negedge clk);
      start = 0;
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_first_awvalid"}, AWVALID, 1);
      chk({tag, "_first_awaddr"}, AWADDR, ADDR_ENABLE);
   endtask

   task automatic wait_done(input string tag, input int lim, output int t1);
      for (int i = 0; i < lim; i++) begin
         if (done) break;
         @(negedge clk);
      end
      chk({tag, "_done"}, done, 1);
      t1 = cyc;
   endtask

   task automatic check_wlog(input string tag, input int n_exp);
      logic [31:0] ea, ed;
      chk({tag, "_nwr"}, wr_addr.size(), n_exp);
      for (int i = 0; i < n_exp && i < wr_addr.size(); i++) begin
         if (i == 0) begin ea = ADDR_ENABLE; ed = 32'd1; end
         else if (i <= NW) begin ea = ADDR_WEIGHT + 4 * (i - 1); ed = WV[i-1]; end
         else if (i == NW + 1) begin ea = ADDR_CTRL; ed = CTRL_START; end
         else begin ea = ADDR_CTRL; ed = CTRL_DONE; end
         chk($sformatf("%s_wa%0d", tag, i), wr_addr[i], ea);
         chk($sformatf("%s_wd%0d", tag, i), wr_data[i], ed);
      end
   endtask

   initial begin
      int t0, t1, k;
      for (int i = 0; i < NW; i++) weights[32*i +: 32] = WV[i];
      repeat (3) @(negedge clk);
      chk("rst_handshake", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
      chk("rst_awaddr", AWADDR, 0);
      chk("rst_araddr", ARADDR, 0);
      chk("rst_wdata", WDATA, 0);
      chk("rst_wstrb", WSTRB, 0);
      chk("rst_status", {busy, done, error}, 0);
      reset = 0;
      @(negedge clk);

      clr(); ctrl_ok_at = 3;
      run_start("zw", t0);
      chk("zw_wstrb", WSTRB, 4'hF);
      wait_done("zw", 1000, t1);
      chk("zw_cycles", t1 - t0 - 1, RUN_CYC);
      chk("zw_status", {busy, done, error}, 3'b010);
      chk("zw_polls", n_ctrl, 3);
      check_wlog("zw", NW + 3);

      clr(); stall = 1; ctrl_ok_at = 3;
      run_start("st", t0);
      wait_done("st", 5000, t1);
      chk("st_status", {busy, done, error}, 3'b010);
      chk("st_stability", viol, 0);
      check_wlog("st", NW + 3);
      stall = 0;

      clr(); err_at = 4; ctrl_ok_at = 3;
      run_start("be", t0);
      wait_done("be", 1000, t1);
      repeat (5) @(negedge clk);
      chk("be_status", {busy, done, error}, 3'b011);
      chk("be_reads", n_rd, 0);
      chk("be_idle", {AWVALID, ARVALID}, 0);
      check_wlog("be", 4);
      err_at = 0;

      clr(); ctrl_ok_at = 0;
      run_start("to", t0);
      wait_done("to", 1000, t1);
      chk("to_status", {busy, done, error}, 3'b011);
      chk("to_polls", n_ctrl, PMAX);
      for (int i = 1; i < ar_cyc.size(); i++)
         chk($sformatf("to_gap%0d", i), ar_cyc[i] - ar_cyc[i-1], GAP + 2);
      check_wlog("to", NW + 2);

      clr(); ctrl_ok_at = 3;
      run_start("rs", t0);
      k = 0;
      while (k < 200 && !(BREADY && AWADDR == 32'h48)) begin
         @(negedge clk);
         k++;
      end
      chk("rs_in_b_phase", BREADY, 1);
      reset = 1;
      #1;
      chk("rs_handshake", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
      chk("rs_status", {busy, done, error}, 0);
      repeat (2) @(negedge clk);
      reset = 0;
      @(negedge clk);
      clr();
      run_start("rr", t0);
      wait_done("rr", 1000, t1);
      chk("rr_status", {busy, done, error}, 3'b010);
      check_wlog("rr", NW + 3);

`ifdef AXI_CFG_READBACK_EN
      clr(); corrupt = 1; ctrl_ok_at = 3;
      run_start("rb", t0);
      wait_done("rb", 1000, t1);
      chk("rb_status", {busy, done, error}, 3'b011);
      chk("rb_reads", n_rd, 7);
      chk("rb_no_ctrl_rd", n_ctrl, 0);
      check_wlog("rb", NW + 1);
      corrupt = 0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
